// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Stalls the pipeline for DATA_W+1 cycles, then pulses res_valid with quotient/remainder.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_div,
    input  logic              ex_mdsign,
    input  logic [DATA_W-1:0] ex_A,
    input  logic [DATA_W-1:0] ex_B,
    input  logic              flush,
    output logic              div_stall,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_lo,
    output logic [DATA_W-1:0] res_hi
);

    localparam int ITER  = DATA_W;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] neg2(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
        if (sgn && v[DATA_W-1]) begin
            return neg2(v);
        end else begin
            return v;
        end
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0]  quo_q, quo_d;
    logic [DATA_W-1:0]  dvs_q, dvs_d;
    logic               sign_quo_q, sign_quo_d;
    logic               sign_rem_q, sign_rem_d;
    logic               res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  res_lo_q, res_lo_d;
    logic [DATA_W-1:0]  res_hi_q, res_hi_d;

    // The shifted partial remainder carries one extra bit so the trial subtract keeps its borrow.
    logic [DATA_W:0]    shifted_s;
    logic [DATA_W:0]    diff_s;
    logic               q_bit_s;
    logic [DATA_W-1:0]  rem_nx_s;
    logic [DATA_W-1:0]  quo_nx_s;

    // One restoring iteration: shift, trial-subtract, keep or restore.
    always_comb begin
        shifted_s = {rem_q, quo_q[DATA_W-1]};
        diff_s    = shifted_s - {1'b0, dvs_q};
        q_bit_s   = ~diff_s[DATA_W];
        rem_nx_s  = q_bit_s ? diff_s[DATA_W-1:0] : shifted_s[DATA_W-1:0];
        quo_nx_s  = {quo_q[DATA_W-2:0], q_bit_s};
    end

    // Next-state, datapath updates and stall request.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        res_valid_d = 1'b0;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        div_stall   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_div) begin
                    div_stall  = 1'b1;
                    state_d    = BUSY;
                    quo_d      = mag(ex_A, ex_mdsign);
                    dvs_d      = mag(ex_B, ex_mdsign);
                    sign_quo_d = ex_mdsign & (ex_A[DATA_W-1] ^ ex_B[DATA_W-1]);
                    sign_rem_d = ex_mdsign & ex_A[DATA_W-1];
                    rem_d      = '0;
                    count_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                div_stall = 1'b1;
                rem_d     = rem_nx_s;
                quo_d     = quo_nx_s;
                count_d   = count_q + CNT_W'(1);
                if (count_q == CNT_W'(ITER - 1)) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    res_lo_d    = sign_quo_q ? neg2(quo_nx_s) : quo_nx_s;
                    res_hi_d    = sign_rem_q ? neg2(rem_nx_s) : rem_nx_s;
                end else begin
                    state_d = BUSY;
                end
            end
            // The divide instruction is still in EX here, so ex_div is not a new request.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d     = IDLE;
            count_d     = '0;
            res_valid_d = 1'b0;
            res_lo_d    = res_lo_q;
            res_hi_d    = res_hi_q;
            div_stall   = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            res_valid_q <= res_valid_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: signed/unsigned results, stall length,
// flush abort, back-to-back issue and asynchronous reset mid-divide.
module tb_div_iter;

    logic        clk;
    logic        reset;
    logic        ex_div;
    logic        ex_mdsign;
    logic [31:0] ex_A;
    logic [31:0] ex_B;
    logic        flush;
    logic        div_stall;
    logic        res_valid;
    logic [31:0] res_lo;
    logic [31:0] res_hi;

    int checks_s;
    int errors_s;

    div_iter #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ex_div    (ex_div),
        .ex_mdsign (ex_mdsign),
        .ex_A      (ex_A),
        .ex_B      (ex_B),
        .flush     (flush),
        .div_stall (div_stall),
        .res_valid (res_valid),
        .res_lo    (res_lo),
        .res_hi    (res_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_s++;
        if (got !== exp) begin
            errors_s++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with the unit idle; returns at posedge+1 of the cycle after DONE.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int stalls;
        logic done;
        stalls    = 0;
        done      = 1'b0;
        ex_div    = 1'b1;
        ex_mdsign = sgn;
        ex_A      = a;
        ex_B      = b;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (res_valid) begin
                done = 1'b1;
            end else begin
                if (div_stall) stalls++;
                @(posedge clk);
                #1;
            end
        end
        check_val({tag, " done"}, {31'd0, done}, 32'd1);
        check_val({tag, " stall_len"}, stalls, 32'd33);
        check_val({tag, " stall_in_done"}, {31'd0, div_stall}, 32'd0);
        check_val({tag, " lo"}, res_lo, exp_lo);
        check_val({tag, " hi"}, res_hi, exp_hi);
        ex_div = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, " valid_pulse"}, {31'd0, res_valid}, 32'd0);
        check_val({tag, " lo_hold"}, res_lo, exp_lo);
    endtask

    initial begin
        int vcount;
        checks_s  = 0;
        errors_s  = 0;
        reset     = 1'b1;
        ex_div    = 1'b0;
        ex_mdsign = 1'b0;
        ex_A      = 32'd0;
        ex_B      = 32'd0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst valid", {31'd0, res_valid}, 32'd0);
        check_val("rst lo", res_lo, 32'd0);
        check_val("rst hi", res_hi, 32'd0);
        check_val("rst stall", {31'd0, div_stall}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_div("u100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2);
        do_div("s-7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
        do_div("s7_-2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1);
        do_div("s-100_-7",32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE);
        do_div("s_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0);
        do_div("u7_0",    32'd7,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd7);

        // Flush at C+10 aborts the divide.
        ex_div    = 1'b1;
        ex_mdsign = 1'b0;
        ex_A      = 32'd100;
        ex_B      = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check_val("flush stall", {31'd0, div_stall}, 32'd0);
        @(posedge clk);
        #1;
        flush  = 1'b0;
        ex_div = 1'b0;
        #1;
        check_val("flush idle", {31'd0, div_stall}, 32'd0);
        check_val("flush valid", {31'd0, res_valid}, 32'd0);
        check_val("flush lo", res_lo, 32'hFFFF_FFFF);
        check_val("flush hi", res_hi, 32'd7);
        @(posedge clk);
        #1;
        do_div("u9_3",    32'd9,          32'd3,          1'b0, 32'd3,          32'd0);

        // Back-to-back: second start lands in the cycle after DONE.
        do_div("u20_6",   32'd20,         32'd6,          1'b0, 32'd3,          32'd2);
        do_div("u15_4",   32'd15,         32'd4,          1'b0, 32'd3,          32'd3);

        // Asynchronous reset at C+5.
        ex_div    = 1'b1;
        ex_mdsign = 1'b0;
        ex_A      = 32'd100;
        ex_B      = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        reset  = 1'b1;
        ex_div = 1'b0;
        #1;
        check_val("arst stall", {31'd0, div_stall}, 32'd0);
        check_val("arst lo", res_lo, 32'd0);
        check_val("arst hi", res_hi, 32'd0);
        check_val("arst valid", {31'd0, res_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (res_valid) vcount++;
        end
        check_val("arst no_valid", vcount, 32'd0);
        check_val("arst lo_after", res_lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_s, errors_s);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative 32-bit radix-2 restoring divider in the EX stage. It executes DIV/DIVU.
- It consumes the ID/EX register outputs ex_div, ex_mdsign, ex_A and ex_B.
- It drives div_stall back to the pipeline-register stall inputs, freezing the divide instruction in EX until the quotient and remainder are ready.
- The result goes to the HI/LO write path, qualified by res_valid.

Parameters:
- DATA_W, 32, operand and result width; ITER = DATA_W iterations.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ex_div  in  1  EX holds a divide instruction
- ex_mdsign  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- ex_A  in  DATA_W  dividend, GPR[rs]
- ex_B  in  DATA_W  divisor, GPR[rt]
- flush  in  1  pipeline refresh (exception/eret); kills the operation
- div_stall  out  1  combinational; stall IF/ID/EX this cycle
- res_valid  out  1  registered one-cycle pulse; res_hi/res_lo valid
- res_lo  out  DATA_W  quotient
- res_hi  out  DATA_W  remainder

Behaviour:
- Reset: asynchronous, active-high.
  - Clears state to IDLE; counter, res_valid, res_lo, res_hi all 0.
  - Reset mid-operation aborts the divide; no res_valid is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If ex_div && !flush, latch operands at the clock edge and go to BUSY (cycle C).
  - Latched values: |A|, |B| (magnitudes only when ex_mdsign=1), sign_q = A[31]^B[31], sign_r = A[31] (both 0 when unsigned).
  - Clear the 33-bit partial remainder and the quotient; count = 0.
- BUSY, each cycle:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from rem.
  - If non-negative, keep the difference and set the quotient bit to 1; else restore and set it to 0.
  - count++. After the 32nd iteration (count == 31 at the edge) go to DONE.
- Entering DONE:
  - res_lo = sign_q ? -quo : quo.
  - res_hi = sign_r ? -rem : rem.
  - res_valid = 1 for exactly that cycle.
- DONE: ex_div is ignored, since the same instruction is still in EX. Next state is always IDLE.
- div_stall = (IDLE && ex_div && !flush) || BUSY.
  - High for exactly 33 cycles (C .. C+32); low in DONE (C+33), when the instruction advances.
- res_lo/res_hi hold their values after DONE until the next completed divide.
- Back-to-back divides: a new ex_div in the cycle after DONE (state IDLE) starts normally.
- flush:
  - Has priority in every state: next state IDLE, counter cleared.
  - div_stall forced low in the flush cycle.
  - A flush in BUSY suppresses res_valid; res_lo/res_hi keep their old values.
  - A flush coincident with DONE does not cancel the already-asserted res_valid. Writeback gating is downstream.
- Divide by zero: no exception; the natural restoring result is produced.
  - Quotient magnitude = 0xFFFFFFFF, remainder magnitude = |A|, then the sign fix is applied.
- Signed overflow 0x80000000 / -1: magnitudes 0x80000000/1, sign fix gives lo = 0x80000000, hi = 0.
- Arithmetic:
  - Partial remainder is 33 bits, so the trial subtract carries the borrow.
  - Negation is two's complement on DATA_W bits.
  - Magnitude of 0x80000000 is 0x80000000 taken as unsigned.

Test Plan:
- Unsigned 100/7 (ex_mdsign=0, ex_div held while stalled):
  - div_stall high 33 cycles.
  - At C+33: res_valid=1, res_lo=14, res_hi=2. res_valid low at C+34.
- Signed -7/2 (A=0xFFFFFFF9, B=2): res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF.
- Signed 7/-2: res_lo=0xFFFFFFFD, res_hi=1.
- Signed 0x80000000/0xFFFFFFFF: res_lo=0x80000000, res_hi=0.
- Unsigned 7/0: res_lo=0xFFFFFFFF, res_hi=7.
- Start 100/7, assert flush at C+10:
  - div_stall low at C+10; state IDLE at C+11; no res_valid.
  - res_lo/res_hi unchanged.
  - Then 9/3 unsigned immediately: res_lo=3, res_hi=0 after 33 stall cycles.
- Back-to-back 20/6 then 15/4 unsigned:
  - Second start in the cycle after DONE.
  - Results 3/2 then 3/3, each with a single res_valid pulse.
- Reset at C+5 during BUSY: immediately IDLE, div_stall=0, outputs zero, no res_valid afterwards.
